// File: rtl/uart_tx_oversampled_if.sv
// Request/serial-line bundle for uart_tx_oversampled; master drives ticks and requests.
interface uart_tx_oversampled_if #(
  parameter int unsigned NB_DATA = 8
) ();
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_tx_done;
  logic               o_busy;

  modport master (
    output i_tick, i_tx_start, i_data,
    input  o_tx, o_tx_done, o_busy
  );

  modport slave (
    input  i_tick, i_tx_start, i_data,
    output o_tx, o_tx_done, o_busy
  );
endinterface

// File: rtl/uart_tx_oversampled.sv
// UART transmitter paced by a 16x oversampling tick; LSB first, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_oversampled #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_tx_oversampled_if.slave  bus
);

  localparam int unsigned TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned BW       = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t             state, state_n;
  logic [TW-1:0]      tick_cnt, tick_n;
  logic [BW-1:0]      bit_cnt, bit_n;
  logic [NB_DATA-1:0] shift, shift_n;
  logic               tx_q, tx_n;
  logic               done_q, done_n;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_n;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    done_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n = parity_q;
`endif

    case (state)
      ST_IDLE: begin
        if (bus.i_tx_start) begin
          state_n  = ST_START;
          shift_n  = bus.i_data;
`ifdef UART_TX_PARITY_EN
          parity_n = ^bus.i_data;
`endif
        end
      end

      ST_START: begin
        if (bus.i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_n = ST_DATA;
            tick_n  = '0;
          end else begin
            tick_n  = tick_cnt + 1'b1;
          end
        end
      end

      // Each bit boundary clears the tick counter even when the state holds in DATA.
      ST_DATA: begin
        if (bus.i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_n  = '0;
            shift_n = shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_n   = '0;
`ifdef UART_TX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bit_n   = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bus.i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_n = ST_STOP;
            tick_n  = '0;
          end else begin
            tick_n  = tick_cnt + 1'b1;
          end
        end
      end
`endif

      ST_STOP: begin
        if (bus.i_tick) begin
          if (tick_cnt == SB_LAST) begin
            state_n = ST_IDLE;
            tick_n  = '0;
            done_n  = 1'b1;
          end else begin
            tick_n  = tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        tick_n  = '0;
        bit_n   = '0;
      end
    endcase

    // Line level is registered from the next state so the start bit appears one cycle after acceptance.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_n = parity_q;
`endif
      default:   tx_n = 1'b1;
    endcase
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_tx_done = done_q;
  assign bus.o_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_oversampled.sv
// Scoreboard bench for uart_tx_oversampled: stimulus queues expected frames, a line monitor decodes and checks them.
module tb_uart_tx_oversampled;

  localparam int unsigned NB   = 8;
  localparam int unsigned OS   = 16;
  localparam int unsigned SB   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = NB + 3;
  localparam int unsigned N_FRAMES   = 8;
`else
  localparam int unsigned FRAME_BITS = NB + 2;
  localparam int unsigned N_FRAMES   = 6;
`endif
  localparam int unsigned FRAME_TICKS = (FRAME_BITS - 1) * OS + SB;

  typedef struct {
    logic [NB-1:0] data;
    logic          par;
  } exp_t;

  logic clk;
  logic rst;
  logic tick_en;
  int   tick_div;
  int   n_tests;
  int   n_fail;
  int   done_count;
  logic busy_d;
  logic samp[$];
  exp_t exp_q[$];

  uart_tx_oversampled_if #(.NB_DATA(NB)) bus ();

  uart_tx_oversampled #(
    .NB_DATA    (NB),
    .SB_TICK    (SB),
    .OVERSAMPLE (OS)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Tick every 4 clocks, driven just after the rising edge.
  initial begin
    bus.i_tick = 1'b0;
    tick_div   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_div   = (tick_div == 3) ? 0 : tick_div + 1;
        bus.i_tick = (tick_div == 3);
      end else begin
        bus.i_tick = 1'b0;
      end
    end
  end

  task automatic finalize_frame();
    exp_t                  e;
    logic                  stable;
    logic [FRAME_BITS-1:0] got;
    logic [FRAME_BITS-1:0] expf;
    int                    base;
    int                    len;
    stable = 1'b1;
    got    = '0;
    check("pending_frame", 32'(exp_q.size() != 0), 32'd1);
    check("frame_ticks", 32'(samp.size()), 32'(FRAME_TICKS));
    for (int k = 0; k < int'(FRAME_BITS); k++) begin
      base = k * int'(OS);
      len  = (k == int'(FRAME_BITS) - 1) ? int'(SB) : int'(OS);
      if (base < samp.size()) begin
        got[k] = samp[base];
        for (int j = 0; j < len; j++)
          if (base + j < samp.size() && samp[base + j] !== samp[base]) stable = 1'b0;
      end
    end
    check("bit_stability", 32'(stable), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
      expf = {1'b1, e.par, e.data, 1'b0};
`else
      expf = {1'b1, e.data, 1'b0};
`endif
      check("frame_bits", 32'(got), 32'(expf));
    end
    samp.delete();
  endtask

  // Monitor: collect the line level on every tick cycle of a frame, decode on o_tx_done.
  initial begin
    busy_d     = 1'b0;
    done_count = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        samp.delete();
        busy_d = 1'b0;
      end else begin
        if (bus.o_busy && bus.i_tick) samp.push_back(bus.o_tx);
        if (busy_d && !bus.o_busy) check("busy_until_done", 32'(bus.o_tx_done), 32'd1);
        if (bus.o_tx_done) begin
          done_count++;
          finalize_frame();
        end
        busy_d = bus.o_busy;
      end
    end
  end

  task automatic start_frame(input logic [NB-1:0] d, input logic par);
    exp_t e;
    e.data = d;
    e.par  = par;
    @(posedge clk);
    #1;
    bus.i_tx_start = 1'b1;
    bus.i_data     = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.i_tx_start = 1'b0;
    bus.i_data     = ~d;
    @(negedge clk);
    check("start_latency_tx", 32'(bus.o_tx), 32'd0);
    check("start_busy", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.o_tx_done) break;
    end
    check("done_timeout", 32'(bus.o_tx_done), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge clk); while (!bus.i_tick);
    end
  endtask

  initial begin
    logic ok;
    exp_t e;
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    tick_en        = 1'b1;
    bus.i_tx_start = 1'b0;
    bus.i_data     = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.o_tx), 32'd1);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_done", 32'(bus.o_tx_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0xA5: line 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5, 1'b0);
    wait_done(2000);
    repeat (10) @(posedge clk);

    // Request mid-frame is ignored and not queued.
    start_frame(8'h3C, 1'b0);
    wait_ticks(40);
    @(posedge clk);
    #1;
    bus.i_tx_start = 1'b1;
    bus.i_data     = 8'hFF;
    @(posedge clk);
    #1 bus.i_tx_start = 1'b0;
    wait_done(2000);
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (bus.o_busy || bus.o_tx_done) ok = 1'b0;
    end
    check("no_queued_frame", 32'(ok), 32'd1);

    // Held start: back-to-back frames.
    @(posedge clk);
    #1;
    bus.i_tx_start = 1'b1;
    bus.i_data     = 8'h81;
    e.data = 8'h81;
    e.par  = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    wait_done(2000);
    @(negedge clk);
    check("b2b_start_tx", 32'(bus.o_tx), 32'd0);
    check("b2b_busy", 32'(bus.o_busy), 32'd1);
    @(posedge clk);
    #1 bus.i_tx_start = 1'b0;
    wait_done(2000);
    repeat (10) @(posedge clk);

    // Reset during data bit 3 of 0x55 (bit 3 = 0).
    start_frame(8'h55, 1'b0);
    wait_ticks(72);
    check("pre_reset_bit3", 32'(bus.o_tx), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("abort_tx", 32'(bus.o_tx), 32'd1);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_tx_done || bus.o_busy) ok = 1'b0;
    end
    check("no_done_after_abort", 32'(ok), 32'd1);
    start_frame(8'h0F, 1'b0);
    wait_done(2000);
    repeat (10) @(posedge clk);

    // Tick stall during data bit 5 of 0x20 (bit 5 = 1).
    start_frame(8'h20, 1'b1);
    wait_ticks(104);
    tick_en = 1'b0;
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b1) ok = 1'b0;
    end
    check("stall_hold", 32'(ok), 32'd1);
    tick_en = 1'b1;
    wait_done(2000);
    repeat (10) @(posedge clk);

`ifdef UART_TX_PARITY_EN
    start_frame(8'h07, 1'b1);
    wait_done(2000);
    repeat (10) @(posedge clk);
    start_frame(8'h03, 1'b0);
    wait_done(2000);
    repeat (10) @(posedge clk);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_count), 32'(N_FRAMES));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
